// File: rtl/id_stage_hazard_if.sv
// ID stage bundle: IF instruction, WB writeback, ID/EX register and stats.
// master = upstream/testbench side, slave = id_stage_hazard.
interface id_stage_hazard_if #(
  parameter int DATA  = 32,
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic [31:0]      instruction;
  logic             flush;
  logic             wb_en;
  logic [REG_W-1:0] wb_addr;
  logic [DATA-1:0]  wb_data;
  logic             stall_out;
  logic             out_valid;
  logic [9:0]       out_ctrl;
  logic [DATA-1:0]  out_rs1_data;
  logic [DATA-1:0]  out_rs2_data;
  logic [DATA-1:0]  out_imm;
  logic [REG_W-1:0] out_rs1;
  logic [REG_W-1:0] out_rs2;
  logic [REG_W-1:0] out_rd;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] cnt_total;
  logic [CNT_W-1:0] cnt_arith;
  logic [CNT_W-1:0] cnt_logic;
  logic [CNT_W-1:0] cnt_mem;
  logic [CNT_W-1:0] cnt_ctrl;

  modport master (
    output in_valid, instruction, flush,
    output wb_en, wb_addr, wb_data,
    input  stall_out, out_valid, out_ctrl,
    input  out_rs1_data, out_rs2_data, out_imm,
    input  out_rs1, out_rs2, out_rd,
    input  halted, illegal,
    input  cnt_total, cnt_arith, cnt_logic,
    input  cnt_mem, cnt_ctrl
  );

  modport slave (
    input  in_valid, instruction, flush,
    input  wb_en, wb_addr, wb_data,
    output stall_out, out_valid, out_ctrl,
    output out_rs1_data, out_rs2_data, out_imm,
    output out_rs1, out_rs2, out_rd,
    output halted, illegal,
    output cnt_total, cnt_arith, cnt_logic,
    output cnt_mem, cnt_ctrl
  );
endinterface

// File: rtl/id_stage_hazard.sv
// Decode stage: regfile with WB bypass, ID/EX register, load-use stall,
// flush, sticky HALT/illegal, saturating per-class counters.
// Ports: clk, reset (async, active-high), bus (id_stage_hazard_if.slave).
module id_stage_hazard #(
  parameter int DATA     = 32,
  parameter int REG_NUM  = 32,
  parameter int REG_W    = 5,
  parameter int IMM_SIZE = 16,
  parameter int CNT_W    = 32
) (
  input logic             clk,
  input logic             reset,
  id_stage_hazard_if.slave bus
);
  localparam int RW = 9;
  localparam int MW = 8;
  localparam int MR = 7;
  localparam int S2 = 6;
  localparam int JP = 5;
  localparam int BR = 4;
  localparam int HL = 3;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [DATA-1:0]  r_rf [REG_NUM];
  logic             r_valid;
  logic [9:0]       r_ctrl;
  logic [DATA-1:0]  r_d1, r_d2, r_imm;
  logic [REG_W-1:0] r_rs1, r_rs2, r_rd;
  logic             r_halted, r_illegal;
  logic [CNT_W-1:0] r_tot, r_ari, r_log;
  logic [CNT_W-1:0] r_mem, r_ctl;

  logic [5:0]       w_op;
  logic [REG_W-1:0] w_rs, w_rt, w_rdf;
  logic [DATA-1:0]  w_sext;
  logic [9:0]       w_ctrl;
  logic [REG_W-1:0] w_rs1, w_rs2, w_rd;
  logic [DATA-1:0]  w_imm, w_d1, w_d2;
  logic             w_use2, w_legal;
  logic             w_hz, w_acc;

  assign w_op   = bus.instruction[31:26];
  assign w_rs   = bus.instruction[25:21];
  assign w_rt   = bus.instruction[20:16];
  assign w_rdf  = bus.instruction[15:11];
  assign w_sext = {{(DATA-IMM_SIZE){bus.instruction[IMM_SIZE-1]}},
                   bus.instruction[IMM_SIZE-1:0]};
  assign w_legal = (w_op <= 6'h11);

  // Paired ALU opcodes: even = R-type, odd = immediate form.
  always_comb begin
    w_ctrl = '0;
    w_rs1  = '0;
    w_rs2  = '0;
    w_rd   = '0;
    w_imm  = '0;
    w_use2 = 1'b0;
    unique case (1'b1)
      (w_op <= 6'h0B) && !w_op[0]: begin
        w_ctrl[RW]  = 1'b1;
        w_ctrl[S2]  = 1'b1;
        w_ctrl[2:0] = w_op[3:1];
        w_rs1  = w_rs;
        w_rs2  = w_rt;
        w_rd   = w_rdf;
        w_use2 = 1'b1;
      end
      (w_op <= 6'h0B) && w_op[0]: begin
        w_ctrl[RW]  = 1'b1;
        w_ctrl[2:0] = w_op[3:1];
        w_rs1 = w_rs;
        w_rd  = w_rt;
        w_imm = w_sext;
      end
      w_op == 6'h0C: begin
        w_ctrl[RW] = 1'b1;
        w_ctrl[MR] = 1'b1;
        w_rs1 = w_rs;
        w_rd  = w_rt;
        w_imm = w_sext;
      end
      w_op == 6'h0D: begin
        w_ctrl[MW] = 1'b1;
        w_rs1  = w_rs;
        w_rs2  = w_rt;
        w_use2 = 1'b1;
        w_imm  = w_sext;
      end
      w_op == 6'h0E: begin
        w_ctrl[BR]  = 1'b1;
        w_ctrl[2:0] = 3'd6;
        w_rs1 = w_rs;
        w_imm = w_sext;
      end
      w_op == 6'h0F: begin
        w_ctrl[BR]  = 1'b1;
        w_ctrl[S2]  = 1'b1;
        w_ctrl[2:0] = 3'd7;
        w_rs1  = w_rs;
        w_rs2  = w_rt;
        w_use2 = 1'b1;
        w_imm  = w_sext;
      end
      w_op == 6'h10: begin
        w_ctrl[JP] = 1'b1;
        w_rs1 = w_rs;
      end
      w_op == 6'h11: w_ctrl[HL] = 1'b1;
      default: ;
    endcase
  end

  // Same-cycle WB bypass so decode never sees a stale register.
  assign w_d1 = (w_rs1 == '0) ? '0 :
                (bus.wb_en && bus.wb_addr == w_rs1) ?
                bus.wb_data : r_rf[w_rs1];
  assign w_d2 = (w_rs2 == '0) ? '0 :
                (bus.wb_en && bus.wb_addr == w_rs2) ?
                bus.wb_data : r_rf[w_rs2];

  assign w_hz = bus.in_valid && r_valid && r_ctrl[MR] &&
                (r_rd != '0) &&
                ((r_rd == w_rs1) || (w_use2 && r_rd == w_rs2));
  assign w_acc = bus.in_valid && !w_hz && !bus.flush && !r_halted;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return (c == CMAX) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) r_rf[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Anything but a legal accept loads an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_d1      <= '0;
      r_d2      <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_tot     <= '0;
      r_ari     <= '0;
      r_log     <= '0;
      r_mem     <= '0;
      r_ctl     <= '0;
    end else begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      if (w_acc && !w_legal) r_illegal <= 1'b1;
      if (w_acc && w_legal) begin
        r_valid <= 1'b1;
        r_ctrl  <= w_ctrl;
        r_d1    <= w_d1;
        r_d2    <= w_d2;
        r_imm   <= w_imm;
        r_rs1   <= w_rs1;
        r_rs2   <= w_rs2;
        r_rd    <= w_rd;
        r_tot   <= sat(r_tot);
        if (w_op == 6'h11) r_halted <= 1'b1;
        if (w_op <= 6'h05)      r_ari <= sat(r_ari);
        else if (w_op <= 6'h0B) r_log <= sat(r_log);
        else if (w_op <= 6'h0D) r_mem <= sat(r_mem);
        else                    r_ctl <= sat(r_ctl);
      end
    end
  end

  assign bus.stall_out    = w_hz && !bus.flush && !r_halted;
  assign bus.out_valid    = r_valid;
  assign bus.out_ctrl     = r_ctrl;
  assign bus.out_rs1_data = r_d1;
  assign bus.out_rs2_data = r_d2;
  assign bus.out_imm      = r_imm;
  assign bus.out_rs1      = r_rs1;
  assign bus.out_rs2      = r_rs2;
  assign bus.out_rd       = r_rd;
  assign bus.halted       = r_halted;
  assign bus.illegal      = r_illegal;
  assign bus.cnt_total    = r_tot;
  assign bus.cnt_arith    = r_ari;
  assign bus.cnt_logic    = r_log;
  assign bus.cnt_mem      = r_mem;
  assign bus.cnt_ctrl     = r_ctl;
endmodule

// File: tb/tb_id_stage_hazard.sv
// Bench for id_stage_hazard: opcode-table model checked every negedge,
// plus directed literal checks. Counters narrowed to 4 bits to reach saturation.
module tb_id_stage_hazard;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_stage_hazard_if #(.DATA(32), .REG_W(5), .CNT_W(CW)) bus ();
  id_stage_hazard #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]  c;
    logic [4:0]  s1, s2, d;
    logic [31:0] imm;
    logic        u2, ok;
    int          cls;
  } dec_t;

  // ctrl = {rw,mw,mr,src2,jump,branch,halt,alu[2:0]}
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t r;
    int op;
    logic [4:0] rs, rt, rdf;
    logic [31:0] se;
    op  = int'(ins[31:26]);
    rs  = ins[25:21];
    rt  = ins[20:16];
    rdf = ins[15:11];
    se  = 32'($signed(ins[15:0]));
    r.c = '0; r.s1 = '0; r.s2 = '0; r.d = '0;
    r.imm = '0; r.u2 = 1'b0; r.ok = (op <= 17); r.cls = -1;
    if (op <= 11) begin
      r.c[9] = 1'b1;
      r.c[2:0] = 3'(op / 2);
      r.s1 = rs;
      r.cls = (op <= 5) ? 1 : 2;
      if (op % 2 == 0) begin
        r.s2 = rt; r.d = rdf; r.c[6] = 1'b1; r.u2 = 1'b1;
      end else begin
        r.d = rt; r.imm = se;
      end
    end else begin
      case (op)
        12: begin r.c[9] = 1; r.c[7] = 1; r.s1 = rs; r.d = rt;
                  r.imm = se; r.cls = 3; end
        13: begin r.c[8] = 1; r.s1 = rs; r.s2 = rt; r.u2 = 1;
                  r.imm = se; r.cls = 3; end
        14: begin r.c[4] = 1; r.c[2:0] = 3'd6; r.s1 = rs;
                  r.imm = se; r.cls = 4; end
        15: begin r.c[4] = 1; r.c[6] = 1; r.c[2:0] = 3'd7;
                  r.s1 = rs; r.s2 = rt; r.u2 = 1; r.imm = se;
                  r.cls = 4; end
        16: begin r.c[5] = 1; r.s1 = rs; r.cls = 4; end
        17: begin r.c[3] = 1; r.cls = 4; end
        default: ;
      endcase
    end
    return r;
  endfunction

  logic [31:0] m_rf [32];
  logic        m_v, m_halt, m_ill;
  logic [9:0]  m_c;
  logic [4:0]  m_s1, m_s2, m_d;
  logic [31:0] m_d1, m_d2, m_imm;
  int          m_cnt [5];

  function automatic logic [31:0] rdreg(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_rf[a];
  endfunction

  function automatic logic m_hz();
    dec_t d;
    d = decode(bus.instruction);
    return bus.in_valid && m_v && m_c[7] && m_d != 0 &&
           (m_d == d.s1 || (d.u2 && m_d == d.s2));
  endfunction

  task automatic clear_idex();
    m_v = 0; m_c = '0; m_s1 = '0; m_s2 = '0; m_d = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    m_halt = 0; m_ill = 0;
    clear_idex();
  endtask

  task automatic bump(input int k);
    if (m_cnt[k] < CMAX) m_cnt[k]++;
  endtask

  // One clock edge of the model, using inputs held across the edge.
  task automatic model_step();
    dec_t d;
    logic acc;
    logic [31:0] a, b;
    d = decode(bus.instruction);
    acc = bus.in_valid && !m_hz() && !bus.flush && !m_halt;
    a = rdreg(d.s1);
    b = rdreg(d.s2);
    if (bus.wb_en && bus.wb_addr != 0) m_rf[bus.wb_addr] = bus.wb_data;
    clear_idex();
    if (acc && !d.ok) m_ill = 1;
    if (acc && d.ok) begin
      m_v = 1; m_c = d.c; m_s1 = d.s1; m_s2 = d.s2; m_d = d.d;
      m_d1 = a; m_d2 = b; m_imm = d.imm;
      bump(0);
      bump(d.cls);
      if (d.c[3]) m_halt = 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(bus.stall_out),
          32'(m_hz() && !bus.flush && !m_halt));
      chk("valid", 32'(bus.out_valid), 32'(m_v));
      chk("ctrl", 32'(bus.out_ctrl), 32'(m_c));
      chk("d1", bus.out_rs1_data, m_d1);
      chk("d2", bus.out_rs2_data, m_d2);
      chk("imm", bus.out_imm, m_imm);
      chk("rs1", 32'(bus.out_rs1), 32'(m_s1));
      chk("rs2", 32'(bus.out_rs2), 32'(m_s2));
      chk("rd", 32'(bus.out_rd), 32'(m_d));
      chk("halted", 32'(bus.halted), 32'(m_halt));
      chk("illegal", 32'(bus.illegal), 32'(m_ill));
      chk("c_tot", 32'(bus.cnt_total), 32'(m_cnt[0]));
      chk("c_ari", 32'(bus.cnt_arith), 32'(m_cnt[1]));
      chk("c_log", 32'(bus.cnt_logic), 32'(m_cnt[2]));
      chk("c_mem", 32'(bus.cnt_mem), 32'(m_cnt[3]));
      chk("c_ctl", 32'(bus.cnt_ctrl), 32'(m_cnt[4]));
    end
  end

  function automatic logic [31:0] R(input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {op, s, t, d, 11'h0};
  endfunction

  function automatic logic [31:0] I(input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic set(input logic v, input logic [31:0] ins,
      input logic fl, input logic we, input logic [4:0] wa,
      input logic [31:0] wd);
    bus.in_valid = v; bus.instruction = ins; bus.flush = fl;
    bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    set(0, 32'h0, 0, 0, 5'd0, 32'h0);
  endtask

  logic [31:0] mix [10];

  initial begin
    idle();
    model_reset();
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_total", 32'(bus.cnt_total), 32'h0);

    // add r5,r3,r3 with r3=0x12 arriving on WB this cycle
    set(1, R(6'h00, 3, 3, 5), 0, 1, 5'd3, 32'h12);
    tick();
    chk("byp_valid", 32'(bus.out_valid), 32'h1);
    chk("byp_d1", bus.out_rs1_data, 32'h12);
    chk("byp_d2", bus.out_rs2_data, 32'h12);
    chk("byp_rd", 32'(bus.out_rd), 32'd5);
    chk("byp_arith", 32'(bus.cnt_arith), 32'd1);

    set(0, 32'h0, 0, 1, 5'd1, 32'h100);
    tick();
    // addi r2,r1,-4 while WB attempts r0
    set(1, I(6'h01, 1, 2, 16'hFFFC), 0, 1, 5'd0, 32'hDEAD);
    tick();
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("addi_src2", 32'(bus.out_ctrl[6]), 32'h0);
    chk("addi_rd", 32'(bus.out_rd), 32'd2);
    chk("addi_d1", bus.out_rs1_data, 32'h100);
    set(1, R(6'h00, 0, 0, 7), 0, 0, 5'd0, 32'h0);
    tick();
    chk("r0_read", bus.out_rs1_data, 32'h0);

    // load-use: ldw r4,0(r1); add r6,r4,r1
    set(1, I(6'h0C, 1, 4, 16'h0), 0, 0, 5'd0, 32'h0);
    tick();
    set(1, R(6'h00, 4, 1, 6), 0, 0, 5'd0, 32'h0);
    #1 chk("lu_stall", 32'(bus.stall_out), 32'h1);
    tick();
    chk("lu_bubble", 32'(bus.out_valid), 32'h0);
    chk("lu_stall_end", 32'(bus.stall_out), 32'h0);
    tick();
    chk("lu_issue", 32'(bus.out_valid), 32'h1);
    chk("lu_rd", 32'(bus.out_rd), 32'd6);
    chk("lu_total", 32'(bus.cnt_total), 32'd5);
    idle();
    tick();
    chk("lu_once", 32'(bus.out_valid), 32'h0);

    // ldw r0 then use of r0: no stall
    set(1, I(6'h0C, 1, 0, 16'h4), 0, 0, 5'd0, 32'h0);
    tick();
    set(1, R(6'h00, 0, 1, 6), 0, 0, 5'd0, 32'h0);
    #1 chk("r0_nostall", 32'(bus.stall_out), 32'h0);
    tick();

    // ldw r12 then stw r12: hazard through rs2
    set(1, I(6'h0C, 1, 12, 16'h8), 0, 0, 5'd0, 32'h0);
    tick();
    set(1, I(6'h0D, 1, 12, 16'h0), 0, 0, 5'd0, 32'h0);
    #1 chk("stw_stall", 32'(bus.stall_out), 32'h1);
    tick();
    tick();
    // ldw r13 then addi writing r13: rt is a destination, no stall
    set(1, I(6'h0C, 1, 13, 16'h0), 0, 0, 5'd0, 32'h0);
    tick();
    set(1, I(6'h01, 1, 13, 16'h1), 0, 0, 5'd0, 32'h0);
    #1 chk("itype_nostall", 32'(bus.stall_out), 32'h0);
    tick();

    // flush over a hazarded sub
    set(1, I(6'h0C, 1, 4, 16'h8), 0, 0, 5'd0, 32'h0);
    tick();
    set(1, R(6'h02, 4, 4, 8), 1, 0, 5'd0, 32'h0);
    #1 chk("fl_stall", 32'(bus.stall_out), 32'h0);
    tick();
    chk("fl_bubble", 32'(bus.out_valid), 32'h0);
    chk("fl_total", 32'(bus.cnt_total), 32'd12);

    mix[0] = R(6'h04, 3, 1, 10);
    mix[1] = I(6'h07, 3, 11, 16'h00F0);
    mix[2] = R(6'h0A, 1, 3, 12);
    mix[3] = I(6'h0F, 3, 1, 16'hFFFE);
    mix[4] = I(6'h0D, 1, 3, 16'h0004);
    mix[5] = I(6'h0E, 3, 0, 16'h8000);
    mix[6] = I(6'h10, 1, 0, 16'h0);
    mix[7] = I(6'h0B, 3, 14, 16'h7FFF);
    mix[8] = R(6'h08, 3, 3, 15);
    mix[9] = {6'h12, 26'h0};
    for (int i = 0; i < 10; i++) begin
      set(1, mix[i], 0, 0, 5'd0, 32'h0);
      tick();
    end
    chk("sat_total", 32'(bus.cnt_total), 32'd15);

    set(1, {6'h3F, 26'h0}, 0, 0, 5'd0, 32'h0);
    tick();
    chk("ill_flag", 32'(bus.illegal), 32'h1);
    chk("ill_valid", 32'(bus.out_valid), 32'h0);

    // async reset pulse between edges
    idle();
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("ar_total", 32'(bus.cnt_total), 32'h0);
    chk("ar_illegal", 32'(bus.illegal), 32'h0);
    chk("ar_valid", 32'(bus.out_valid), 32'h0);
    #2 reset = 1'b0;
    set(1, R(6'h00, 3, 3, 9), 0, 0, 5'd0, 32'h0);
    tick();
    chk("ar_rf", bus.out_rs1_data, 32'h0);
    chk("ar_first", 32'(bus.out_valid), 32'h1);

    set(1, {6'h11, 26'h0}, 0, 0, 5'd0, 32'h0);
    tick();
    chk("h_halted", 32'(bus.halted), 32'h1);
    chk("h_ctrl", 32'(bus.out_ctrl[3]), 32'h1);
    chk("h_ctl_cnt", 32'(bus.cnt_ctrl), 32'd1);
    set(1, R(6'h06, 3, 3, 9), 0, 0, 5'd0, 32'h0);
    tick();
    chk("h_ignore", 32'(bus.out_valid), 32'h0);
    chk("h_total", 32'(bus.cnt_total), 32'd2);
    tick();
    chk("h_ctl_hold", 32'(bus.cnt_ctrl), 32'd1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
